instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Consumer end of the program-counter -> program-memory path. Owns a fetch pointer and
//  reads each 2-byte instruction ({opcode byte @A, address byte @A+1}) over a req/ack
//  memory port. Buffers decoded pairs in a small FIFO and presents instr_set/addr_set,
//  with a valid/ready handshake, to the jump decoder and program sorter.
//  A taken jump redirects the block: it flushes the FIFO and restarts fetch at the target.
// PARAMETERS
//  ADDR_W      8   program address width; the pointer wraps modulo 2**ADDR_W
//  DATA_W      8   memory byte width; width of instr_set and addr_set
//  FIFO_DEPTH  2   instruction entries buffered (power of two, >=2)
// PORTS
//  clk             in   1       single clock; all state updates on posedge
//  rst             in   1       asynchronous reset, active-high
//  mem_req         out  1       read request; held high until mem_ack
//  mem_addr        out  ADDR_W  read address; stable while mem_req && !mem_ack
//  mem_ack         in   1       read done; mem_rdata valid this cycle (same-cycle ack legal)
//  mem_rdata       in   DATA_W  read data byte
//  redirect_valid  in   1       taken jump (unconditional, or conditional with status=1)
//  redirect_addr   in   ADDR_W  jump target
//  instr_valid     out  1       FIFO head valid
//  instr_ready     in   1       consumer accepts head this cycle
//  instr_set       out  DATA_W  head opcode byte
//  addr_set        out  DATA_W  head address byte
//  instr_pc        out  ADDR_W  address of the head opcode byte
// BEHAVIOUR
//  Reset (async, immediate): pointer=0, state=OP, FIFO empty, drop=0, op latch=0;
//   mem_req=0, mem_addr=0, instr_valid=0, instr_set=0, addr_set=0, instr_pc=0.
//  FSM states:
//   OP   : mem_req=!full, mem_addr=ptr; on ack latch op_byte, op_pc=ptr -> ARG
//   ARG  : mem_req=1, mem_addr=ptr+1 (mod 2**ADDR_W); on ack push {op,rdata,op_pc},
//          ptr+=2 -> OP
//   DRAIN: mem_req stays high on the held address; on ack discard data -> OP at new ptr
//  Full: a new instruction starts only when the FIFO has a free slot in OP. ARG is never
//   entered unless a slot is reserved, so a push never overflows.
//  Memory handshake: req is never dropped before ack; address never changes mid-request.
//  Latency with zero-wait memory: req@addr0 in cycle 0 after reset release, ack same cycle.
//   Req@addr1 in cycle 1. instr_valid=1 in cycle 2. Throughput: 1 instruction per 2 cycles.
//  Output pop: instr_valid && instr_ready pops the head. Push and pop in one cycle are
//   legal when full; count is unchanged.
//  Redirect (highest priority), on the cycle redirect_valid=1:
//   - FIFO flushed: instr_valid=0 next cycle; any same-cycle pop or push is discarded.
//   - ptr <= redirect_addr.
//   - If mem_req=1 and mem_ack=0, go to DRAIN; else go to OP.
//   - The first request after redirect is at redirect_addr.
//  Redirect during DRAIN: update ptr to the latest target; stay in DRAIN.
//  Wrap: ptr=0xFF fetches opcode@0xFF and arg@0x00; next ptr=0x01. Odd targets are legal.
//  Reset mid-request: mem_req drops immediately. The memory must tolerate an abandoned
//   request.
// STRUCTURE
//  cpu_pkg:
//   - ADDR_W/DATA_W localparams
//   - fetch_state_t enum {OP, ARG, DRAIN}
//   - fetch_entry_t struct {instr, addr, pc}
//  Sub-module fetch_fifo:
//   - parameters: FIFO_DEPTH, entry width
//   - ports: push/pop/flush, full/empty
//   - async reset, registered head
//  Top level holds the FSM, pointer and op latch.
// TESTING
//  1 Reset, zero-wait ROM of bytes 0x00..0xFF with ready=1.
//    -> req addr 0,1,2,3; first valid in cycle 2 with instr=0x00, addr=0x01, pc=0x00.
//  2 ready=0 with zero-wait ROM.
//    -> 2 entries buffered; mem_req=0 in OP; ready=1 drains pc 0x00 then 0x02; fetch resumes.
//  3 Ack delayed 3 cycles.
//    -> mem_addr/mem_req held constant for 4 cycles; the entry is correct.
//  4 Redirect to 0x40 while the ARG request is pending (ack=0).
//    -> DRAIN; FIFO empty; stale byte discarded; next req addr 0x40; head pc=0x40.
//  5 Redirect to 0xFF.
//    -> reqs 0xFF then 0x00; head pc=0xFF, addr=ROM[0x00]; next pc=0x01.
//  6 Reset asserted mid-ARG.
//    -> mem_req and instr_valid are 0 immediately; after release, req addr 0x00.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the program fetch path: widths, fetch FSM states and
// the buffered instruction record handed to the jump decoder and sorter.
package cpu_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        OP    = 2'd0,
        ARG   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [DATA_W-1:0] addr;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO for decoded instruction pairs; flush empties it
// and wins over any same-cycle push or pop.
module fetch_fifo #(
    parameter int FIFO_DEPTH = 2,
    parameter int WIDTH      = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Fetch unit: walks the program two bytes at a time over a req/ack port
// and buffers {opcode, address, pc} entries for the downstream consumer.
module instr_fetch #(
    parameter int ADDR_W     = cpu_pkg::ADDR_W,
    parameter int DATA_W     = cpu_pkg::DATA_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_set,
    output logic [DATA_W-1:0] addr_set,
    output logic [ADDR_W-1:0] instr_pc
);

    import cpu_pkg::fetch_state_t;
    import cpu_pkg::OP;
    import cpu_pkg::ARG;
    import cpu_pkg::DRAIN;

    localparam int EW = 2 * DATA_W + ADDR_W;

    fetch_state_t      state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] op_pc;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] op_byte;
    logic              full;
    logic              empty;
    logic              done;
    logic              push;
    logic [EW-1:0]     wdata;
    logic [EW-1:0]     head;

    always_comb begin
        mem_req  = 1'b0;
        mem_addr = ptr;
        unique case (state)
            OP:      mem_req = !full;
            ARG: begin
                mem_req  = 1'b1;
                mem_addr = ptr + ADDR_W'(1);
            end
            DRAIN: begin
                mem_req  = 1'b1;
                mem_addr = hold_addr;
            end
            default: mem_req = 1'b0;
        endcase
        // An asserted reset abandons any outstanding read at once.
        if (rst) mem_req = 1'b0;
    end

    assign done  = mem_req && mem_ack;
    assign push  = (state == ARG) && done;
    assign wdata = {op_byte, mem_rdata, op_pc};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= OP;
            ptr       <= '0;
            op_byte   <= '0;
            op_pc     <= '0;
            hold_addr <= '0;
        end else if (redirect_valid) begin
            // An unanswered read must still be completed, then thrown away.
            ptr       <= redirect_addr;
            hold_addr <= mem_addr;
            state     <= (mem_req && !mem_ack) ? DRAIN : OP;
        end else begin
            unique case (state)
                OP: begin
                    if (done) begin
                        op_byte <= mem_rdata;
                        op_pc   <= ptr;
                        state   <= ARG;
                    end
                end
                ARG: begin
                    if (done) begin
                        ptr   <= ptr + ADDR_W'(2);
                        state <= OP;
                    end
                end
                DRAIN: begin
                    if (done) state <= OP;
                end
                default: state <= OP;
            endcase
        end
    end

    fetch_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (EW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (instr_ready),
        .flush (redirect_valid),
        .wdata (wdata),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    assign instr_valid = !empty;
    assign {instr_set, addr_set, instr_pc} = head;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: cycle tables, directed corner sequences and a
// randomized run checked against a stream-level model of the fetch order.
module tb_instr_fetch;

    logic       clk;
    logic       rst;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack;
    logic [7:0] mem_rdata;
    logic       redirect_valid;
    logic [7:0] redirect_addr;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr_set;
    logic [7:0] addr_set;
    logic [7:0] instr_pc;

    int errors = 0;
    int checks = 0;

    logic [7:0] rom [256];
    int         lat;
    logic       ack_en;
    int         waitc;

    instr_fetch #(
        .ADDR_W     (8),
        .DATA_W     (8),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_set      (instr_set),
        .addr_set       (addr_set),
        .instr_pc       (instr_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: answers after lat wait cycles, and only while ack_en is high.
    assign mem_ack   = mem_req && ack_en && (waitc >= lat);
    assign mem_rdata = rom[mem_addr];

    always @(posedge clk or posedge rst) begin
        if (rst) waitc <= 0;
        else if (mem_req && !mem_ack) waitc <= waitc + 1;
        else waitc <= 0;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_head(input string name, input logic [7:0] pc);
        logic [7:0] nx;
        nx = pc + 8'd1;
        chk({name, " valid"}, instr_valid, 1);
        chk({name, " pc"}, instr_pc, pc);
        chk({name, " instr"}, instr_set, rom[pc]);
        chk({name, " addr"}, addr_set, rom[nx]);
    endtask

    task automatic chk_req(input string name, input logic [7:0] a);
        chk({name, " req"}, mem_req, 1);
        chk({name, " maddr"}, mem_addr, a);
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        instr_ready    = 1'b0;
        ack_en         = 1'b1;
        lat            = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic next();
        @(negedge clk);
        #1;
    endtask

    typedef struct {
        bit         restart;
        bit         ready;
        bit         req;
        logic [7:0] maddr;
        bit         valid;
        logic [7:0] pc;
    } vec_t;

    vec_t tbl [14];

    initial begin
        logic [7:0] exp_pc;
        logic       prev_pend;
        logic [7:0] prev_addr;
        logic       after_redir;
        int         pops;

        for (int i = 0; i < 256; i++) rom[i] = 8'(i);

        // Zero-wait ROM: ready=1 stream, then ready=0 back-pressure and release.
        tbl[0]  = '{1, 1, 1, 8'h00, 0, 8'h00};
        tbl[1]  = '{0, 1, 1, 8'h01, 0, 8'h00};
        tbl[2]  = '{0, 1, 1, 8'h02, 1, 8'h00};
        tbl[3]  = '{0, 1, 1, 8'h03, 0, 8'h00};
        tbl[4]  = '{0, 1, 1, 8'h04, 1, 8'h02};
        tbl[5]  = '{1, 0, 1, 8'h00, 0, 8'h00};
        tbl[6]  = '{0, 0, 1, 8'h01, 0, 8'h00};
        tbl[7]  = '{0, 0, 1, 8'h02, 1, 8'h00};
        tbl[8]  = '{0, 0, 1, 8'h03, 1, 8'h00};
        tbl[9]  = '{0, 0, 0, 8'h04, 1, 8'h00};
        tbl[10] = '{0, 1, 0, 8'h04, 1, 8'h00};
        tbl[11] = '{0, 1, 1, 8'h04, 1, 8'h02};
        tbl[12] = '{0, 1, 1, 8'h05, 0, 8'h00};
        tbl[13] = '{0, 0, 1, 8'h06, 1, 8'h04};

        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        instr_ready    = 1'b0;
        ack_en         = 1'b1;
        lat            = 0;
        @(negedge clk);
        #1;
        chk("reset req", mem_req, 0);
        chk("reset maddr", mem_addr, 0);
        chk("reset valid", instr_valid, 0);
        chk("reset outs", {instr_set, addr_set, instr_pc}, 0);

        foreach (tbl[i]) begin
            if (tbl[i].restart) do_reset();
            instr_ready = tbl[i].ready;
            #1;
            chk($sformatf("tbl%0d req", i), mem_req, tbl[i].req);
            if (tbl[i].req)
                chk($sformatf("tbl%0d maddr", i), mem_addr, tbl[i].maddr);
            chk($sformatf("tbl%0d valid", i), instr_valid, tbl[i].valid);
            if (tbl[i].valid) chk_head($sformatf("tbl%0d", i), tbl[i].pc);
            @(negedge clk);
        end

        // Three wait cycles per byte: request and address held steady.
        do_reset();
        lat         = 3;
        instr_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk_req($sformatf("slow op c%0d", k), 8'h00);
            chk($sformatf("slow op ack c%0d", k), mem_ack, (k == 3));
            next();
        end
        for (int k = 0; k < 4; k++) begin
            chk_req($sformatf("slow arg c%0d", k), 8'h01);
            next();
        end
        chk_head("slow head", 8'h00);
        lat = 0;

        // Redirect while the argument read is outstanding, retarget in DRAIN.
        do_reset();
        #1;
        next();
        next();
        chk_head("rd pre", 8'h00);
        @(negedge clk);
        ack_en         = 1'b0;
        redirect_valid = 1'b1;
        redirect_addr  = 8'h20;
        #1;
        chk_req("rd arg", 8'h03);
        @(negedge clk);
        redirect_addr = 8'h40;
        #1;
        chk("rd flush valid", instr_valid, 0);
        chk_req("rd drain0", 8'h03);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk_req("rd drain1", 8'h03);
        @(negedge clk);
        ack_en = 1'b1;
        #1;
        chk_req("rd drain2", 8'h03);
        chk("rd drain ack", mem_ack, 1);
        next();
        chk_req("rd new op", 8'h40);
        chk("rd empty", instr_valid, 0);
        next();
        chk_req("rd new arg", 8'h41);
        next();
        chk_head("rd head", 8'h40);

        // Redirect to the top of memory: the pair wraps to address 0.
        do_reset();
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr  = 8'hFF;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk_req("wrap op", 8'hFF);
        next();
        chk_req("wrap arg", 8'h00);
        next();
        chk_head("wrap head", 8'hFF);
        chk_req("wrap next op", 8'h01);
        next();
        next();
        chk_head("wrap next", 8'h01);

        // Reset in the middle of an argument read.
        do_reset();
        #1;
        next();
        next();
        @(negedge clk);
        ack_en = 1'b0;
        #1;
        chk_req("mid arg", 8'h03);
        chk("mid valid", instr_valid, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("mid rst req", mem_req, 0);
        chk("mid rst valid", instr_valid, 0);
        chk("mid rst maddr", mem_addr, 0);
        @(negedge clk);
        rst    = 1'b0;
        ack_en = 1'b1;
        #1;
        chk_req("mid rst resume", 8'h00);

        // Random traffic against the expected pc stream.
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
        do_reset();
        exp_pc      = 8'h00;
        prev_pend   = 1'b0;
        prev_addr   = '0;
        after_redir = 1'b0;
        pops        = 0;
        for (int n = 0; n < 3000; n++) begin
            instr_ready    = ($urandom_range(0, 3) != 0);
            ack_en         = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 29) == 0);
            redirect_addr  = 8'($urandom);
            #1;
            if (prev_pend)
                chk($sformatf("rnd hold c%0d", n), {mem_req, mem_addr},
                    {1'b1, prev_addr});
            if (after_redir)
                chk($sformatf("rnd flushed c%0d", n), instr_valid, 0);
            if (instr_valid && instr_ready && !redirect_valid) begin
                chk_head($sformatf("rnd pop%0d", pops), exp_pc);
                exp_pc = exp_pc + 8'd2;
                pops++;
            end
            if (redirect_valid) exp_pc = redirect_addr;
            prev_pend   = mem_req && !mem_ack;
            prev_addr   = mem_addr;
            after_redir = redirect_valid;
            @(negedge clk);
        end
        redirect_valid = 1'b0;
        ack_en         = 1'b1;
        chk("rnd progress", (pops > 200), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
